// File: rtl/serial_subtractor_pkg.sv
`timescale 1ns/1ps
// Shared definitions for the serial add/subtract family: FSM state codes and default sizing.
package serial_subtractor_pkg;

  localparam int DEFAULT_WIDTH     = 4;
  localparam int DEFAULT_BIT_DELAY = 50;

  typedef logic [1:0] state_t;

  localparam logic [1:0] STATE_IDLE = 2'd0;
  localparam logic [1:0] STATE_RUN  = 2'd1;
  localparam logic [1:0] STATE_DONE = 2'd2;

endpackage

// File: rtl/one_bit_subtractor.sv
`timescale 1ns/1ps
// Single-bit full subtractor cell built from gate primitives; the serial datapath
// pushes one operand bit pair through it per clock.
module one_bit_subtractor
  import serial_subtractor_pkg::*;
#(
  parameter int BIT_DELAY = DEFAULT_BIT_DELAY
) (
  input  logic a_i,
  input  logic b_i,
  input  logic borrow_i,
  output logic diff_o,
  output logic borrow_o
);

  wire aXorB;
  wire aXnorB;
  wire notA;
  wire genBorrow;
  wire propBorrow;
  wire diffW;
  wire borrowW;

  // A borrow is generated by 0-1 and propagated through equal bit pairs.
  xor  #(BIT_DELAY) gXorAb   (aXorB, a_i, b_i);
  not  #(BIT_DELAY) gNotXor  (aXnorB, aXorB);
  not  #(BIT_DELAY) gNotA    (notA, a_i);
  and  #(BIT_DELAY) gGen     (genBorrow, notA, b_i);
  and  #(BIT_DELAY) gProp    (propBorrow, aXnorB, borrow_i);
  or   #(BIT_DELAY) gBorrow  (borrowW, genBorrow, propBorrow);
  xor  #(BIT_DELAY) gDiff    (diffW, aXorB, borrow_i);

  assign diff_o   = diffW;
  assign borrow_o = borrowW;

endmodule

// File: rtl/serial_subtractor.sv
`timescale 1ns/1ps
// Bit-serial unsigned subtractor: loads a and b on start, retires one bit per clock
// LSB first, and publishes (a - b) mod 2^WIDTH plus the final borrow.
module serial_subtractor
  import serial_subtractor_pkg::*;
#(
  parameter int WIDTH     = DEFAULT_WIDTH,
  parameter int BIT_DELAY = DEFAULT_BIT_DELAY
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             borrow_out
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] opA_q, opA_d;
  logic [WIDTH-1:0] opB_q, opB_d;
  logic [WIDTH-1:0] partial_q, partial_d;
  logic [WIDTH-1:0] diff_q, diff_d;
  logic [CW-1:0]    count_q, count_d;
  logic             borrow_q, borrow_d;
  logic             borrowOut_q, borrowOut_d;
  logic             done_q, done_d;

  logic bitDiff;
  logic bitBorrow;

  one_bit_subtractor #(
    .BIT_DELAY(BIT_DELAY)
  ) uBit (
    .a_i      (opA_q[0]),
    .b_i      (opB_q[0]),
    .borrow_i (borrow_q),
    .diff_o   (bitDiff),
    .borrow_o (bitBorrow)
  );

  // done is registered off the DONE state, so the pulse lands one edge after the
  // result is published and still fires when a new start is taken from DONE.
  always_comb begin
    state_d     = state_q;
    opA_d       = opA_q;
    opB_d       = opB_q;
    partial_d   = partial_q;
    diff_d      = diff_q;
    count_d     = count_q;
    borrow_d    = borrow_q;
    borrowOut_d = borrowOut_q;
    done_d      = (state_q == STATE_DONE);

    case (state_q)
      STATE_IDLE, STATE_DONE: begin
        if (start) begin
          opA_d     = a;
          opB_d     = b;
          partial_d = '0;
          count_d   = '0;
          borrow_d  = 1'b0;
          state_d   = STATE_RUN;
        end else begin
          state_d = STATE_IDLE;
        end
      end

      STATE_RUN: begin
        opA_d     = opA_q >> 1;
        opB_d     = opB_q >> 1;
        partial_d = {bitDiff, partial_q[WIDTH-1:1]};
        borrow_d  = bitBorrow;
        count_d   = count_q + CW'(1);
        if (count_q == LAST_BIT) begin
          diff_d      = {bitDiff, partial_q[WIDTH-1:1]};
          borrowOut_d = bitBorrow;
          state_d     = STATE_DONE;
        end
      end

      default: begin
        state_d = STATE_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= STATE_IDLE;
      opA_q       <= '0;
      opB_q       <= '0;
      partial_q   <= '0;
      diff_q      <= '0;
      count_q     <= '0;
      borrow_q    <= 1'b0;
      borrowOut_q <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      opA_q       <= opA_d;
      opB_q       <= opB_d;
      partial_q   <= partial_d;
      diff_q      <= diff_d;
      count_q     <= count_d;
      borrow_q    <= borrow_d;
      borrowOut_q <= borrowOut_d;
      done_q      <= done_d;
    end
  end

  assign busy       = (state_q == STATE_RUN);
  assign done       = done_q;
  assign diff       = diff_q;
  assign borrow_out = borrowOut_q;

endmodule

// File: tb/tb_serial_subtractor.sv
`timescale 1ns/1ps
// Self-checking bench for serial_subtractor: a timeline model checked every cycle,
// plus directed scenarios with hand-computed results.
module tb_serial_subtractor;

  localparam int W = 4;

  logic         clk;
  logic         rst;
  logic         start;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         busy;
  logic         done;
  logic [W-1:0] diff;
  logic         borrow_out;

  int checks = 0;
  int errors = 0;

  serial_subtractor #(
    .WIDTH     (W),
    .BIT_DELAY (50)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .a          (a),
    .b          (b),
    .busy       (busy),
    .done       (done),
    .diff       (diff),
    .borrow_out (borrow_out)
  );

  initial clk = 1'b0;
  always #500 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s actual=%0d required=%0d at %0t", name, actual, expected, $time);
    end
  endtask

  // Timeline model: an op accepted at edge n is busy after edges n..n+W-1,
  // publishes its result at edge n+W and pulses done after edge n+W+1.
  int           edgeNo       = 0;
  int           lastAccept   = -1000;
  int           completeEdge = -1000;
  logic [W-1:0] pendDiff     = '0;
  logic         pendBorrow   = 1'b0;
  logic [W-1:0] expDiff      = '0;
  logic         expBorrow    = 1'b0;
  logic         expBusy      = 1'b0;
  logic         expDone      = 1'b0;
  bit           modelValid   = 1'b0;

  always @(posedge clk) begin
    int t;
    edgeNo++;
    if (rst) begin
      lastAccept   = -1000;
      completeEdge = -1000;
      expDiff      = '0;
      expBorrow    = 1'b0;
    end else begin
      if (edgeNo == lastAccept + W) begin
        expDiff      = pendDiff;
        expBorrow    = pendBorrow;
        completeEdge = edgeNo;
      end
      if (start && edgeNo > lastAccept + W) begin
        lastAccept = edgeNo;
        t = int'(a) - int'(b);
        if (t < 0) t = t + (1 << W);
        pendDiff   = W'(t);
        pendBorrow = (a < b);
      end
    end
    expBusy    = (edgeNo < lastAccept + W);
    expDone    = !rst && (edgeNo == completeEdge + 1);
    modelValid = 1'b1;
  end

  always @(negedge clk) begin
    if (modelValid) begin
      checkOutput("model_busy", 32'(busy), 32'(expBusy));
      checkOutput("model_done", 32'(done), 32'(expDone));
      checkOutput("model_diff", 32'(diff), 32'(expDiff));
      checkOutput("model_borrow", 32'(borrow_out), 32'(expBorrow));
    end
  end

  // Presents one start pulse; returns at the negedge just after the accepting edge
  // with the operand inputs scrambled so late changes cannot leak in.
  task automatic applyStimulus(input logic [W-1:0] ia, input logic [W-1:0] ib);
    @(negedge clk);
    a     = ia;
    b     = ib;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    a     = W'($urandom);
    b     = W'($urandom);
  endtask

  task automatic waitDone(output int cyc, output int busyCnt);
    cyc     = 1;
    busyCnt = 0;
    while (done !== 1'b1 && cyc < 20) begin
      if (busy === 1'b1) busyCnt++;
      @(negedge clk);
      cyc++;
    end
  endtask

  task automatic runOp(input string name, input logic [W-1:0] ia, input logic [W-1:0] ib,
                       input logic [W-1:0] eDiff, input logic eBorrow);
    int cyc;
    int busyCnt;
    applyStimulus(ia, ib);
    waitDone(cyc, busyCnt);
    checkOutput({name, "_latency"}, 32'(cyc), 32'd6);
    checkOutput({name, "_busyCycles"}, 32'(busyCnt), 32'd4);
    checkOutput({name, "_diff"}, 32'(diff), 32'(eDiff));
    checkOutput({name, "_borrow"}, 32'(borrow_out), 32'(eBorrow));
    @(negedge clk);
    checkOutput({name, "_donePulseEnds"}, 32'(done), 32'd0);
  endtask

  initial begin
    #10_000_000;
    $display("[TB] FAIL watchdog timeout");
    $fatal(1, "[TB] simulation did not finish");
  end

  initial begin
    int pulses;
    int firstCyc, secondCyc;
    logic [W-1:0] firstDiff, secondDiff;
    logic firstBorrow, secondBorrow;
    int cyc;
    int busyCnt;
    int order[256];
    int tmp;
    int j;
    int ea, eb, ed;

    rst   = 1'b1;
    start = 1'b0;
    a     = '0;
    b     = '0;
    @(negedge clk);
    @(negedge clk);
    checkOutput("reset_busy", 32'(busy), 32'd0);
    checkOutput("reset_done", 32'(done), 32'd0);
    checkOutput("reset_diff", 32'(diff), 32'd0);
    checkOutput("reset_borrow", 32'(borrow_out), 32'd0);
    rst = 1'b0;

    runOp("op_9_3", 4'd9, 4'd3, 4'd6, 1'b0);
    runOp("op_3_9", 4'd3, 4'd9, 4'd10, 1'b1);
    runOp("op_0_15", 4'd0, 4'd15, 4'd1, 1'b1);
    runOp("op_0_0", 4'd0, 4'd0, 4'd0, 1'b0);

    // Start pulsed again during RUN must be ignored.
    applyStimulus(4'd12, 4'd5);
    pulses    = 0;
    firstDiff = '0;
    for (int c = 1; c <= 10; c++) begin
      if (done === 1'b1) begin
        pulses++;
        firstDiff   = diff;
        firstBorrow = borrow_out;
      end
      if (c == 2) begin
        start = 1'b1;
        a     = 4'd1;
        b     = 4'd1;
      end
      if (c == 3) start = 1'b0;
      @(negedge clk);
    end
    checkOutput("ignoreStart_pulses", 32'(pulses), 32'd1);
    checkOutput("ignoreStart_diff", 32'(firstDiff), 32'd7);
    checkOutput("ignoreStart_borrow", 32'(firstBorrow), 32'd0);

    // Reset at the second RUN edge aborts the operation.
    applyStimulus(4'd12, 4'd5);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checkOutput("abort_busy", 32'(busy), 32'd0);
    checkOutput("abort_done", 32'(done), 32'd0);
    checkOutput("abort_diff", 32'(diff), 32'd0);
    checkOutput("abort_borrow", 32'(borrow_out), 32'd0);
    pulses = 0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      if (done === 1'b1) pulses++;
    end
    checkOutput("abort_noDone", 32'(pulses), 32'd0);
    runOp("afterAbort_7_2", 4'd7, 4'd2, 4'd5, 1'b0);

    // Back-to-back with start held high across the DONE cycle.
    @(negedge clk);
    a         = 4'd15;
    b         = 4'd1;
    start     = 1'b1;
    pulses    = 0;
    firstCyc  = 0;
    secondCyc = 0;
    for (int c = 1; c <= 14; c++) begin
      @(negedge clk);
      if (done === 1'b1) begin
        pulses++;
        if (pulses == 1) begin
          firstCyc    = c;
          firstDiff   = diff;
          firstBorrow = borrow_out;
        end else begin
          secondCyc    = c;
          secondDiff   = diff;
          secondBorrow = borrow_out;
        end
      end
      if (c == 2) begin
        a = 4'd2;
        b = 4'd4;
      end
      if (c == 6) start = 1'b0;
    end
    checkOutput("b2b_pulses", 32'(pulses), 32'd2);
    checkOutput("b2b_firstCycle", 32'(firstCyc), 32'd6);
    checkOutput("b2b_firstDiff", 32'(firstDiff), 32'd14);
    checkOutput("b2b_firstBorrow", 32'(firstBorrow), 32'd0);
    checkOutput("b2b_secondCycle", 32'(secondCyc), 32'd11);
    checkOutput("b2b_secondDiff", 32'(secondDiff), 32'd14);
    checkOutput("b2b_secondBorrow", 32'(secondBorrow), 32'd1);

    // All 256 operand pairs in shuffled order.
    for (int i = 0; i < 256; i++) order[i] = i;
    for (int i = 255; i > 0; i--) begin
      j        = int'($urandom_range(i, 0));
      tmp      = order[i];
      order[i] = order[j];
      order[j] = tmp;
    end
    for (int i = 0; i < 256; i++) begin
      ea = order[i] / 16;
      eb = order[i] % 16;
      ed = (ea - eb + 16) % 16;
      applyStimulus(W'(ea), W'(eb));
      waitDone(cyc, busyCnt);
      checkOutput($sformatf("sweep_latency_%0d_%0d", ea, eb), 32'(cyc), 32'd6);
      checkOutput($sformatf("sweep_diff_%0d_%0d", ea, eb), 32'(diff), 32'(ed));
      checkOutput($sformatf("sweep_borrow_%0d_%0d", ea, eb), 32'(borrow_out), 32'(ea < eb));
    end

    @(negedge clk);
    @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
